// File: rtl/sub_bus_dma_copy.sv
// Bus-master block copier: reads each source word, then writes it to the destination.
// Takes 3 cycles per word when granted; a low i_bus_grant freezes RD/CAP/WR in place.
module sub_bus_dma_copy #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  bus_clock,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_src_addr,
  input  logic [ADDR_WIDTH-1:0] i_dst_addr,
  input  logic [15:0]           i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [15:0]           o_remaining,
  input  logic                  i_bus_grant,
  output logic                  o_bus_we,
  output logic [ADDR_WIDTH-1:0] o_bus_addr,
  output logic [DATA_WIDTH-1:0] o_bus_data_write,
  input  logic [DATA_WIDTH-1:0] i_bus_data_read
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_src;
  logic [ADDR_WIDTH-1:0] r_dst;
  logic [DATA_WIDTH-1:0] r_data;
  logic [15:0]           r_remaining;
  logic                  w_last_word;

  assign w_last_word = (r_remaining <= 16'd1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = (i_len != 16'd0) ? S_RD : S_FIN;
        end
      end
      S_RD: begin
        if (i_bus_grant) w_state_nxt = S_CAP;
      end
      S_CAP: begin
        if (i_bus_grant) w_state_nxt = S_WR;
      end
      S_WR: begin
        if (i_bus_grant) w_state_nxt = w_last_word ? S_FIN : S_RD;
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge bus_clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_data      <= '0;
      r_remaining <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_src       <= i_src_addr;
            r_dst       <= i_dst_addr;
            r_remaining <= i_len;
          end
        end
        S_CAP: begin
          // Address is still on the bus here, so the responder output is stable.
          if (i_bus_grant) r_data <= i_bus_data_read;
        end
        S_WR: begin
          if (i_bus_grant) begin
            r_src       <= r_src + ADDR_ONE;
            r_dst       <= r_dst + ADDR_ONE;
            r_remaining <= r_remaining - 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    o_busy           = 1'b0;
    o_done           = 1'b0;
    o_bus_we         = 1'b0;
    o_bus_addr       = '0;
    o_bus_data_write = '0;
    case (r_state)
      S_RD, S_CAP: begin
        o_busy     = 1'b1;
        o_bus_addr = r_src;
      end
      S_WR: begin
        o_busy           = 1'b1;
        o_bus_addr       = r_dst;
        o_bus_data_write = r_data;
        o_bus_we         = i_bus_grant;
      end
      S_FIN: begin
        o_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign o_remaining = r_remaining;

endmodule
